mam_mem_arbiter: RTL and testbench

- Round-robin arbiter that shares one memory-access port (request / write / read channels) between N_REQ requesters, e.g. the MAM plus further debug or DMA masters.
- Grants the port for a whole transaction: the address phase plus all data beats.
- Sits between the requesters and the system memory adapter.
- Guarantees that beats never interleave across requesters.

---
 rtl/mam_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mam_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mam_mem_arbiter.sv
// Round-robin arbiter sharing one memory-access port between N_REQ requesters.
// Ownership spans the whole transaction (address phase plus all data beats).
module mam_mem_arbiter #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ADDR_WIDTH = 64,
    localparam int unsigned BEAT_W    = 14,
    localparam int unsigned STRB_W    = DATA_WIDTH / 8,
    localparam int unsigned GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [N_REQ-1:0]            s_req_valid,
    output logic [N_REQ-1:0]            s_req_ready,
    input  logic [N_REQ-1:0]            s_req_rw,
    input  logic [N_REQ*ADDR_WIDTH-1:0] s_req_addr,
    input  logic [N_REQ-1:0]            s_req_burst,
    input  logic [N_REQ*BEAT_W-1:0]     s_req_beats,
    input  logic [N_REQ-1:0]            s_write_valid,
    output logic [N_REQ-1:0]            s_write_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0] s_write_data,
    input  logic [N_REQ*STRB_W-1:0]     s_write_strb,
    output logic [N_REQ-1:0]            s_read_valid,
    output logic [DATA_WIDTH-1:0]       s_read_data,
    input  logic [N_REQ-1:0]            s_read_ready,
    output logic                        req_valid,
    input  logic                        req_ready,
    output logic                        req_rw,
    output logic [ADDR_WIDTH-1:0]       req_addr,
    output logic                        req_burst,
    output logic [BEAT_W-1:0]           req_beats,
    output logic                        write_valid,
    input  logic                        write_ready,
    output logic [DATA_WIDTH-1:0]       write_data,
    output logic [STRB_W-1:0]           write_strb,
    input  logic                        read_valid,
    input  logic [DATA_WIDTH-1:0]       read_data,
    output logic                        read_ready,
    output logic                        busy,
    output logic [GW-1:0]               grant
);

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_e;

    state_e             state_q, state_d;
    logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [GW-1:0]      grant_nxt;
    logic [GW-1:0]      idx;
    logic               found;
    int unsigned        cand;

    logic [ADDR_WIDTH-1:0] addr_a  [N_REQ];
    logic [BEAT_W-1:0]     beats_a [N_REQ];
    logic [DATA_WIDTH-1:0] wdata_a [N_REQ];
    logic [STRB_W-1:0]     wstrb_a [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_a[g]  = s_req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign beats_a[g] = s_req_beats[g*BEAT_W +: BEAT_W];
        assign wdata_a[g] = s_write_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign wstrb_a[g] = s_write_strb[g*STRB_W +: STRB_W];
    end

    // Priority pointer after a completed transaction: the finishing owner goes last.
    assign grant_nxt = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);
    assign busy      = (state_q != IDLE);
    assign grant     = grant_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        beat_cnt_d    = beat_cnt_q;
        found         = 1'b0;
        idx           = '0;
        cand          = 0;
        s_req_ready   = '0;
        s_write_ready = '0;
        s_read_valid  = '0;
        s_read_data   = '0;
        req_valid     = 1'b0;
        req_rw        = 1'b0;
        req_addr      = '0;
        req_burst     = 1'b0;
        req_beats     = '0;
        write_valid   = 1'b0;
        write_data    = '0;
        write_strb    = '0;
        read_ready    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Cyclic search starting at rr_ptr.
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    cand = (32'(rr_ptr_q) + i) % N_REQ;
                    idx  = GW'(cand);
                    if (!found && s_req_valid[idx]) begin
                        found   = 1'b1;
                        grant_d = idx;
                    end
                end
                if (found) state_d = ADDR;
            end
            ADDR: begin
                req_valid            = s_req_valid[grant_q];
                req_rw               = s_req_rw[grant_q];
                req_addr             = addr_a[grant_q];
                req_burst            = s_req_burst[grant_q];
                req_beats            = beats_a[grant_q];
                s_req_ready[grant_q] = req_ready;
                if (!req_valid) begin
                    state_d = IDLE;
                end else if (req_ready) begin
                    // A zero-length burst still carries one beat.
                    beat_cnt_d = (req_burst && (req_beats != '0)) ? req_beats : BEAT_W'(1);
                    state_d    = req_rw ? WDATA : RDATA;
                end
            end
            WDATA: begin
                write_valid            = s_write_valid[grant_q];
                write_data             = wdata_a[grant_q];
                write_strb             = wstrb_a[grant_q];
                s_write_ready[grant_q] = write_ready;
                if (write_valid && write_ready) begin
                    beat_cnt_d = beat_cnt_q - BEAT_W'(1);
                    if (beat_cnt_q == BEAT_W'(1)) begin
                        rr_ptr_d = grant_nxt;
                        state_d  = IDLE;
                    end
                end
            end
            RDATA: begin
                s_read_valid[grant_q] = read_valid;
                s_read_data           = read_data;
                read_ready            = s_read_ready[grant_q];
                if (read_valid && read_ready) begin
                    beat_cnt_d = beat_cnt_q - BEAT_W'(1);
                    if (beat_cnt_q == BEAT_W'(1)) begin
                        rr_ptr_d = grant_nxt;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mam_mem_arbiter.sv
// Directed bench for mam_mem_arbiter with three requesters: a per-cycle vector
// table for round-robin arbitration plus hand-written multi-cycle sequences.
module tb_mam_mem_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned BW = 14;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned GW = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N-1:0]      s_req_valid, s_req_ready, s_req_rw, s_req_burst;
    logic [N*AW-1:0]   s_req_addr;
    logic [N*BW-1:0]   s_req_beats;
    logic [N-1:0]      s_write_valid, s_write_ready;
    logic [N*DW-1:0]   s_write_data;
    logic [N*SW-1:0]   s_write_strb;
    logic [N-1:0]      s_read_valid, s_read_ready;
    logic [DW-1:0]     s_read_data;
    logic              req_valid, req_ready, req_rw, req_burst;
    logic [AW-1:0]     req_addr;
    logic [BW-1:0]     req_beats;
    logic              write_valid, write_ready;
    logic [DW-1:0]     write_data;
    logic [SW-1:0]     write_strb;
    logic              read_valid, read_ready;
    logic [DW-1:0]     read_data;
    logic              busy;
    logic [GW-1:0]     grant;

    logic [AW-1:0] t_addr  [N];
    logic [BW-1:0] t_beats [N];
    logic [DW-1:0] t_wdata [N];
    logic [SW-1:0] t_wstrb [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign s_req_addr[g*AW +: AW]   = t_addr[g];
        assign s_req_beats[g*BW +: BW]  = t_beats[g];
        assign s_write_data[g*DW +: DW] = t_wdata[g];
        assign s_write_strb[g*SW +: SW] = t_wstrb[g];
    end

    mam_mem_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_rw(s_req_rw),
        .s_req_addr(s_req_addr), .s_req_burst(s_req_burst), .s_req_beats(s_req_beats),
        .s_write_valid(s_write_valid), .s_write_ready(s_write_ready),
        .s_write_data(s_write_data), .s_write_strb(s_write_strb),
        .s_read_valid(s_read_valid), .s_read_data(s_read_data), .s_read_ready(s_read_ready),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_addr(req_addr),
        .req_burst(req_burst), .req_beats(req_beats),
        .write_valid(write_valid), .write_ready(write_ready), .write_data(write_data),
        .write_strb(write_strb),
        .read_valid(read_valid), .read_data(read_data), .read_ready(read_ready),
        .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    // Per-cycle vector: requester valids and read-side inputs, then expected outputs.
    typedef struct packed {
        logic [2:0] vld;
        logic       rd_vld;
        logic [2:0] s_rd_rdy;
        logic       e_busy;
        logic [1:0] e_grant;
        logic [2:0] e_s_req_rdy;
        logic [2:0] e_s_rd_vld;
        logic       e_rd_rdy;
    } vec_t;

    vec_t tbl[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_req(input logic [1:0] r, input logic rw, input logic [AW-1:0] a,
                           input logic b, input logic [BW-1:0] n);
        s_req_rw[r]    = rw;
        s_req_burst[r] = b;
        t_addr[r]      = a;
        t_beats[r]     = n;
    endtask

    // Called just after a negative edge so the pulse sits between active edges.
    task automatic do_reset();
        s_req_valid   = '0;
        s_write_valid = '0;
        s_read_ready  = '0;
        read_valid    = 1'b0;
        write_ready   = 1'b0;
        req_ready     = 1'b0;
        #1 rstn = 1'b0;
        #2 rstn = 1'b1;
    endtask

    int   cnt0, cnt1, nth, order_bad, data_bad, ready_bad, nbeats;
    logic [4:0] pat;
    logic       pbit;

    initial begin
        rstn = 1'b0;
        s_req_rw = '0; s_req_burst = '0; s_read_ready = '0;
        for (int i = 0; i < N; i++) begin
            t_addr[i] = '0; t_beats[i] = '0; t_wdata[i] = '0; t_wstrb[i] = '0;
        end

        //           vld    rdv  srdy  busy grant sreqrdy srdvld rdrdy
        tbl.push_back('{3'b111, 1'b1, 3'b111, 1'b0, 2'd0, 3'b000, 3'b000, 1'b0});
        tbl.push_back('{3'b111, 1'b1, 3'b111, 1'b1, 2'd0, 3'b001, 3'b000, 1'b0});
        tbl.push_back('{3'b111, 1'b1, 3'b111, 1'b1, 2'd0, 3'b000, 3'b001, 1'b1});
        tbl.push_back('{3'b111, 1'b1, 3'b111, 1'b0, 2'd0, 3'b000, 3'b000, 1'b0});
        tbl.push_back('{3'b111, 1'b1, 3'b111, 1'b1, 2'd1, 3'b010, 3'b000, 1'b0});
        tbl.push_back('{3'b111, 1'b1, 3'b111, 1'b1, 2'd1, 3'b000, 3'b010, 1'b1});
        tbl.push_back('{3'b111, 1'b1, 3'b111, 1'b0, 2'd1, 3'b000, 3'b000, 1'b0});
        tbl.push_back('{3'b111, 1'b1, 3'b111, 1'b1, 2'd2, 3'b100, 3'b000, 1'b0});
        tbl.push_back('{3'b111, 1'b1, 3'b111, 1'b1, 2'd2, 3'b000, 3'b100, 1'b1});
        tbl.push_back('{3'b111, 1'b1, 3'b111, 1'b0, 2'd2, 3'b000, 3'b000, 1'b0});
        tbl.push_back('{3'b111, 1'b1, 3'b111, 1'b1, 2'd0, 3'b001, 3'b000, 1'b0});
        tbl.push_back('{3'b111, 1'b1, 3'b111, 1'b1, 2'd0, 3'b000, 3'b001, 1'b1});

        // Reset with busy-looking inputs: every output must still be zero.
        s_req_valid = 3'b111; s_write_valid = 3'b111; read_valid = 1'b1;
        req_ready = 1'b1; write_ready = 1'b1; s_read_ready = 3'b111;
        read_data = 32'hDEAD_BEEF; t_addr[0] = 16'hFFFF; t_wdata[0] = 32'h1111_2222;
        #3;
        check("reset_ctrl", 64'({busy, grant, s_req_ready, s_write_ready, s_read_valid,
                                 req_valid, write_valid, read_ready}), 64'd0);
        check("reset_data", 64'({write_data, s_read_data}), 64'd0);
        check("reset_addr", 64'({req_addr, req_beats, write_strb}), 64'd0);

        // Round-robin table: three requesters with continuous single-beat reads.
        s_req_rw = '0; s_req_burst = '0; req_ready = 1'b1;
        s_write_valid = '0; read_data = 32'h1234_5678;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < tbl.size(); k++) begin
            s_req_valid  = tbl[k].vld;
            read_valid   = tbl[k].rd_vld;
            s_read_ready = tbl[k].s_rd_rdy;
            #1;
            check($sformatf("rr_vec%0d", k),
                  64'({busy, grant, s_req_ready, s_read_valid, read_ready}),
                  64'({tbl[k].e_busy, tbl[k].e_grant, tbl[k].e_s_req_rdy,
                       tbl[k].e_s_rd_vld, tbl[k].e_rd_rdy}));
            @(negedge clk);
        end

        // Single read from requester 0.
        do_reset();
        @(negedge clk);
        set_req(2'd0, 1'b0, 16'h1000, 1'b0, 14'd0);
        s_req_valid = 3'b001; req_ready = 1'b1; s_read_ready = 3'b011;
        @(negedge clk); #1;
        check("a_addr_phase", 64'({req_valid, req_rw, req_burst, req_addr, s_req_ready}),
              64'({1'b1, 1'b0, 1'b0, 16'h1000, 3'b001}));
        @(negedge clk);
        s_req_valid = 3'b000; read_valid = 1'b1; read_data = 32'hA5A5_A5A5;
        #1;
        check("a_read_beat", 64'({s_read_valid, read_ready, s_read_data}),
              64'({3'b001, 1'b1, 32'hA5A5_A5A5}));
        @(negedge clk); #1;
        check("a_back_idle", 64'({busy, s_read_valid, read_ready}), 64'd0);
        read_valid = 1'b0;
        set_req(2'd1, 1'b0, 16'h1100, 1'b0, 14'd0);
        s_req_valid = 3'b011;
        @(negedge clk); #1;
        check("a_rr_next_grant", 64'({busy, grant}), 64'({1'b1, 2'd1}));

        // Simultaneous 4-beat write bursts from requesters 0 and 1.
        do_reset();
        @(negedge clk);
        set_req(2'd0, 1'b1, 16'h2000, 1'b1, 14'd4);
        set_req(2'd1, 1'b1, 16'h3000, 1'b1, 14'd4);
        t_wdata[0] = 32'hAAAA_0000; t_wstrb[0] = 4'hF;
        t_wdata[1] = 32'hBBBB_0000; t_wstrb[1] = 4'h3;
        s_req_valid = 3'b011; s_write_valid = 3'b011; req_ready = 1'b1; write_ready = 1'b1;
        cnt0 = 0; cnt1 = 0; nth = 0; order_bad = 0; data_bad = 0; ready_bad = 0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (cnt0 == 4) begin s_req_valid[0] = 1'b0; s_write_valid[0] = 1'b0; end
            if (cnt1 == 4) begin s_req_valid[1] = 1'b0; s_write_valid[1] = 1'b0; end
            #1;
            if (busy && grant == 2'd0 && s_write_ready[1]) ready_bad++;
            if (busy && grant == 2'd1 && s_write_ready[0]) ready_bad++;
            if (write_valid && write_ready) begin
                if (grant == 2'd0) begin
                    cnt0++;
                    if (write_data !== 32'hAAAA_0000 || write_strb !== 4'hF) data_bad++;
                    if (nth >= 4) order_bad++;
                end else begin
                    cnt1++;
                    if (write_data !== 32'hBBBB_0000 || write_strb !== 4'h3) data_bad++;
                    if (nth < 4) order_bad++;
                end
                nth++;
            end
        end
        check("b_beats_req0", 64'(cnt0), 64'd4);
        check("b_beats_req1", 64'(cnt1), 64'd4);
        check("b_order", 64'(order_bad), 64'd0);
        check("b_data", 64'(data_bad), 64'd0);
        check("b_other_ready", 64'(ready_bad), 64'd0);

        // Read burst of 3 with requester-side backpressure 1,0,1,0,1.
        do_reset();
        @(negedge clk);
        set_req(2'd2, 1'b0, 16'h4000, 1'b1, 14'd3);
        s_req_valid = 3'b100; req_ready = 1'b1; read_valid = 1'b1; read_data = 32'h0BAD_F00D;
        @(negedge clk); #1;
        check("c_grant", 64'({grant, s_req_ready}), 64'({2'd2, 3'b100}));
        @(negedge clk);
        s_req_valid = 3'b000;
        pat = 5'b10101; nbeats = 0;
        for (int i = 0; i < 5; i++) begin
            pbit = pat[0];
            pat  = pat >> 1;
            s_read_ready = {pbit, 2'b00};
            #1;
            check($sformatf("c_track%0d", i), 64'({read_ready, s_read_valid}),
                  64'({pbit, 3'b100}));
            if (read_valid && read_ready) nbeats++;
            @(negedge clk);
        end
        #1;
        check("c_beats", 64'(nbeats), 64'd3);
        check("c_done", 64'(busy), 64'd0);

        // Write burst of 2 stalled for 5 cycles by the memory side.
        read_valid = 1'b0; s_read_ready = '0;
        set_req(2'd1, 1'b1, 16'h5000, 1'b1, 14'd2);
        t_wdata[1] = 32'hCAFE_0001;
        s_req_valid = 3'b010; s_write_valid = 3'b010; write_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        s_req_valid = 3'b000;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("w_stall%0d", i), 64'({busy, grant, write_valid, s_write_ready}),
                  64'({1'b1, 2'd1, 1'b1, 3'b000}));
            @(negedge clk);
        end
        write_ready = 1'b1;
        #1;
        check("w_first", 64'({busy, s_write_ready, write_data}), 64'({1'b1, 3'b010, 32'hCAFE_0001}));
        @(negedge clk); #1;
        check("w_second", 64'({busy, s_write_ready}), 64'({1'b1, 3'b010}));
        @(negedge clk); #1;
        check("w_done", 64'(busy), 64'd0);

        // Zero-length burst counts as one beat.
        s_write_valid = 3'b000;
        set_req(2'd0, 1'b1, 16'h6000, 1'b1, 14'd0);
        t_wdata[0] = 32'h0000_0ABC;
        s_req_valid = 3'b001; s_write_valid = 3'b001;
        @(negedge clk); #1;
        check("d_addr", 64'({req_valid, req_burst, req_beats, grant}),
              64'({1'b1, 1'b1, 14'd0, 2'd0}));
        @(negedge clk);
        s_req_valid = 3'b000;
        #1;
        check("d_beat", 64'({busy, write_valid, s_write_ready}), 64'({1'b1, 1'b1, 3'b001}));
        @(negedge clk); #1;
        check("d_done", 64'({busy, s_write_ready}), 64'd0);

        // Reset in the middle of an 8-beat write from requester 2.
        s_write_valid = 3'b000;
        set_req(2'd2, 1'b1, 16'h7000, 1'b1, 14'd8);
        t_wdata[2] = 32'h7777_7777; t_wstrb[2] = 4'hF;
        s_req_valid = 3'b100; s_write_valid = 3'b100;
        @(negedge clk);
        @(negedge clk);
        s_req_valid = 3'b000;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("e_mid_burst", 64'({busy, grant, write_valid}), 64'({1'b1, 2'd2, 1'b1}));
        #1 rstn = 1'b0;
        #1;
        check("e_async_ctrl", 64'({busy, grant, write_valid, s_write_ready, req_valid,
                                   s_req_ready, read_ready}), 64'd0);
        check("e_async_data", 64'({write_data, write_strb}), 64'd0);
        #1 rstn = 1'b1;
        s_write_valid = 3'b000;
        @(negedge clk);
        set_req(2'd1, 1'b0, 16'h8000, 1'b0, 14'd0);
        s_req_valid = 3'b010;
        #1;
        check("e_idle_after", 64'({busy, grant}), 64'd0);
        @(negedge clk); #1;
        check("e_new_grant", 64'({busy, grant, s_req_ready, req_addr}),
              64'({1'b1, 2'd1, 3'b010, 16'h8000}));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
